// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, 33-cycle fixed latency, reg-file write-back.
// Define DIV_EN to build the divide/remainder datapath; otherwise div ops complete with no write.
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            a_rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      wb_addr,
   output logic            wb_en
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } state_t;

   state_t state, state_nx;

   logic [2:0]      op_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] opa;
   logic            sa, sb;
   logic [5:0]      cnt;
   logic [63:0]     acc;
   logic [63:0]     acc_step;

   logic            sgn_a, sgn_b;
   logic            neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;

   logic [32:0]     mul_sum;
   logic [63:0]     prod;
   logic [XLEN-1:0] fin_res;
   logic            fin_we;

`ifdef DIV_EN
   logic [XLEN-1:0] opb;
   logic [32:0]     div_sh;
   logic [32:0]     div_df;
   logic [XLEN-1:0] quo, rem;
   logic            div0;
`endif

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (1'b1)
         (op == 3'b001),
         (op == 3'b100),
         (op == 3'b110): begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         (op == 3'b010): sgn_a = 1'b1;
         default: ;
      endcase
   end

   assign neg_a = sgn_a & rs1_val[XLEN-1];
   assign neg_b = sgn_b & rs2_val[XLEN-1];
   assign mag_a = neg_a ? -rs1_val : rs1_val;
   assign mag_b = neg_b ? -rs2_val : rs2_val;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (cnt == 6'd31) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // acc: multiply = {partial high, remaining multiplier}; divide = {remainder, quotient}
   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);

   always_comb begin
`ifdef DIV_EN
      div_sh = acc[63:31];
      div_df = div_sh - {1'b0, opb};
      if (!op_q[2])
         acc_step = {mul_sum, acc[31:1]};
      else if (div_df[32])
         acc_step = {div_sh[31:0], acc[30:0], 1'b0};
      else
         acc_step = {div_df[31:0], acc[30:0], 1'b1};
`else
      acc_step = op_q[2] ? acc : {mul_sum, acc[31:1]};
`endif
   end

   assign prod = (sa ^ sb) ? -acc : acc;

`ifdef DIV_EN
   assign quo  = acc[31:0];
   assign rem  = acc[63:32];
   assign div0 = (opb == '0);
`endif

   always_comb begin
      fin_res = '0;
      fin_we  = (rd_q != 5'd0);
      if (!op_q[2]) begin
         fin_res = (op_q[1:0] == 2'b00) ? acc[31:0] : prod[63:32];
      end else begin
`ifdef DIV_EN
         // MIN/-1 falls out of the magnitude path; only divide-by-zero needs a patch
         if (!op_q[1])
            fin_res = div0 ? '1 : ((sa ^ sb) ? -quo : quo);
         else
            fin_res = sa ? -rem : rem;
`else
         fin_we = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         op_q    <= '0;
         rd_q    <= '0;
         opa     <= '0;
`ifdef DIV_EN
         opb     <= '0;
`endif
         sa      <= 1'b0;
         sb      <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         done    <= 1'b0;
         wb_en   <= 1'b0;
         result  <= '0;
         wb_addr <= '0;
      end else begin
         done  <= 1'b0;
         wb_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_q <= op;
                  rd_q <= rd_addr;
                  opa  <= mag_a;
`ifdef DIV_EN
                  opb  <= mag_b;
`endif
                  sa   <= neg_a;
                  sb   <= neg_b;
                  cnt  <= '0;
                  acc  <= {32'd0, op[2] ? mag_a : mag_b};
               end
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               acc <= acc_step;
            end
            FINISH: begin
               result  <= fin_res;
               wb_addr <= rd_q;
               done    <= 1'b1;
               wb_en   <= fin_we;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an expected-result queue.
// Division checks follow DIV_EN the same way the design does.
module tb_mul_div_unit;

   logic        clk;
   logic        a_rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  wb_addr;
   logic        wb_en;

   mul_div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .a_rst   (a_rst),
      .start   (start),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .wb_addr (wb_addr),
      .wb_en   (wb_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic [4:0]  addr;
      logic        we;
   } exp_t;

   exp_t sbq[$];
   int   ntests = 0;
   int   nfail  = 0;
   int   done_cnt = 0;
   int   wbe_cnt  = 0;

   always @(negedge clk) begin
      if (done === 1'b1)  done_cnt++;
      if (wb_en === 1'b1) wbe_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] er,
                        input logic ew, input bit push);
      start   = 1'b1;
      op      = o;
      rs1_val = a;
      rs2_val = b;
      rd_addr = rd;
      if (push) sbq.push_back('{tag, er, rd, ew});
   endtask

   task automatic await(input bit hold, output int lat, output int bc);
      bit   seen;
      exp_t e;
      seen = 0;
      lat  = 0;
      bc   = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (i == 0 && !hold) begin
            start   = 1'b0;
            rs1_val = $urandom;
            rs2_val = $urandom;
         end
         lat++;
         if (busy === 1'b1) bc++;
         if (done === 1'b1) seen = 1;
      end
      start = 1'b0;
      chk("done_seen", {31'd0, seen}, 32'd1);
      if (seen) begin
         chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_result"}, result, e.res);
            chk({e.tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, e.addr});
            chk({e.tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, e.we});
            chk({e.tag, "_busy_low"}, {31'd0, busy}, 32'd0);
         end
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] er,
                      input logic ew);
      int lat, bc;
      issue(tag, o, a, b, rd, er, ew, 1);
      await(0, lat, bc);
      chk({tag, "_latency"}, lat, 34);
   endtask

   initial begin
      int lat, bc, d0, w0;
      a_rst   = 1'b0;
      start   = 1'b0;
      op      = 3'b000;
      rs1_val = '0;
      rs2_val = '0;
      rd_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
      a_rst = 1'b1;
      @(negedge clk);

      issue("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1, 1);
      await(0, lat, bc);
      chk("mul_latency", lat, 34);
      chk("mul_busy_cycles", bc, 33);

      run("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 1);
      run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 1);
      run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 1);
      run("mulh_neg", 3'b001, 32'hFFFFFFFF, 32'd5, 5'd9, 32'hFFFFFFFF, 1);

`ifdef DIV_EN
      run("div", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 1);
      run("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 1);
      run("divu", 3'b101, 32'hFFFFFFFF, 32'd2, 5'd12, 32'h7FFFFFFF, 1);
      run("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
      run("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
      run("rem_by0_neg", 3'b110, 32'hFFFFFFF9, 32'd0, 5'd15, 32'hFFFFFFF9, 1);
      run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
      run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1);
`else
      run("div_nodiv", 3'b100, 32'd10, 32'd2, 5'd10, 32'd0, 0);
      run("remu_nodiv", 3'b111, 32'd7, 32'd3, 5'd11, 32'd0, 0);
`endif

      run("mul_rd0", 3'b000, 32'd3, 32'd5, 5'd0, 32'd15, 0);

      @(negedge clk);
      #1;
      d0 = done_cnt;
      issue("mul_hold", 3'b011, 32'h00010000, 32'h00010000, 5'd18, 32'd1, 1, 1);
      await(1, lat, bc);
      repeat (40) @(negedge clk);
      #1;
      chk("hold_one_done", done_cnt - d0, 1);

      @(negedge clk);
      run("b2b_first", 3'b000, 32'd6, 32'd7, 5'd3, 32'd42, 1);
      issue("b2b_second", 3'b000, 32'hFFFFFFFE, 32'd9, 5'd4, 32'hFFFFFFEE, 1, 1);
      await(0, lat, bc);
      chk("b2b_gap", lat, 34);

      issue("discarded", 3'b000, 32'd11, 32'd13, 5'd20, 32'd0, 0, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      a_rst = 1'b0;
      #1;
      d0 = done_cnt;
      w0 = wbe_cnt;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("midrst_wb_en", {31'd0, wb_en}, 32'd0);
      repeat (3) @(negedge clk);
      a_rst = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_no_wb", wbe_cnt - w0, 0);

      @(negedge clk);
      run("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd21, 32'h0000000C, 1);
      chk("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
